vector_wb_arbiter: RTL and testbench
====================================

# vector_wb_arbiter

Writeback stage of the vector unit. Sits directly downstream of the vector lanes' functional units (ALU, MUL, DIV/SQRT pipes) and upstream of the VEGGIE vector register file write port. It buffers per-source results in small FIFOs and arbitrates round-robin onto a single registered writeback port, with per-element write enables (vmask) passed through.

## Interface
Parameters:
- NUM_SRC, 3, number of FU result sources
- NUM_ELEMENTS, 32, elements per vector register
- ELEM_W, 16, element width (FP16)
- VREG_ADDR_W, 5, vector register index width
- DEPTH, 2, entries per source FIFO (power of two, >= 2)

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- src_valid  in  NUM_SRC  per-source result valid
- src_ready  out  NUM_SRC  per-source FIFO not full
- src_vd  in  NUM_SRC*VREG_ADDR_W  destination register, source i at slice i
- src_data  in  NUM_SRC*NUM_ELEMENTS*ELEM_W  result vector, source i at slice i
- src_mask  in  NUM_SRC*NUM_ELEMENTS  per-element write enables
- wb_valid  out  1  writeback request to VEGGIE
- wb_ready  in  1  VEGGIE accepts write this cycle
- wb_vd  out  VREG_ADDR_W  destination register
- wb_data  out  NUM_ELEMENTS*ELEM_W  write data
- wb_mask  out  NUM_ELEMENTS  per-element write enables
- wb_src  out  $clog2(NUM_SRC)  index of granted source
- busy  out  1  any FIFO non-empty or wb_valid high
- wb_stall_cnt  out  32  (VECTOR_WB_PERF_EN only)
- wb_done_cnt  out  32  (VECTOR_WB_PERF_EN only)

One clock; reset is asynchronous and active-low (CLK, nRST).

## Operation
- Per source: circular FIFO, DEPTH entries, {vd, data, mask}; rd/wr pointers with extra wrap bit; push on src_valid & src_ready.
- src_ready[i] = !full[i]; depends only on registered count, never on same-cycle pop (no full-pass-through).
- Output stage, two states: IDLE (wb_valid=0), HOLD (wb_valid=1).
- Load condition: (IDLE or wb_ready) and at least one FIFO non-empty. On load: grant one source, pop its head into output regs, wb_src=grant, go/stay HOLD.
- HOLD & wb_ready & no non-empty FIFO -> IDLE.
- HOLD & !wb_ready: wb_vd/wb_data/wb_mask/wb_src stable; no pop.
- Arbitration: round-robin over non-empty FIFOs, search starts at (last_grant+1) mod NUM_SRC; last_grant updates only on load.
- Ordering: FIFO order within a source; no ordering across sources (scoreboard prevents same-vd WAW between sources).
- All-zero mask entries are still issued unchanged.
- Push into a FIFO whose head is popped same cycle: both occur; count unchanged.

## Timing
- Reset: wb_valid=0, wb_vd=0, wb_data=0, wb_mask=0, wb_src=0, all FIFOs empty, last_grant=NUM_SRC-1 (source 0 first), counters 0; src_ready all 1; busy=0.
- Latency: src handshake at edge k -> wb_valid=1 with that payload after edge k+1 (if output free).
- Throughput: one writeback per cycle under continuous wb_ready.
- wb_valid never drops without wb_ready.
- Reset mid-operation: all buffered and pending results discarded, outputs return to reset values immediately.

## Configuration
- VECTOR_WB_PERF_EN defined: wb_stall_cnt increments each cycle wb_valid & !wb_ready; wb_done_cnt increments on each wb_valid & wb_ready; both saturate at 32'hFFFF_FFFF, cleared only by reset.
- Not defined: both ports and counters absent; functional behaviour identical.

## Test plan
- Single push src1 vd=7, data=all 16'h3C00, mask=32'hFFFF_FFFF, wb_ready=1 -> wb_valid one cycle after handshake, wb_vd=7, wb_src=1, busy low next cycle.
- All three sources push every cycle, wb_ready=1 -> grants 0,1,2,0,1,2...; src_ready deasserts only when a FIFO reaches DEPTH.
- wb_ready=0 for 5 cycles with src0 pushing -> src0 accepts 2 entries, src_ready[0]=0, wb payload stable; wb_stall_cnt=5 (perf build); release -> entries drain in push order.
- Mask 32'h0000_0001 on src2 -> wb_mask=32'h0000_0001, data passed bit-exact.
- Assert nRST with all FIFOs full and wb_valid=1 -> wb_valid=0, src_ready=3'b111, busy=0 immediately; no stale writeback after release.
- Push and pop same FIFO same cycle at count 1 -> count stays 1, order preserved.

Source files
------------

// File: rtl/vector_wb_arbiter.sv
// Vector writeback arbiter: per-source result FIFOs, round-robin onto one registered VEGGIE write port.
// Latency: source handshake at edge k shows on wb_* after edge k+1 when the output stage is free.
// Backpressure: wb_ready low holds the wb_* payload; src_ready[i] drops when FIFO i is full. Option: VECTOR_WB_PERF_EN.

module vector_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;

    assign do_push  = push_vld & ~full;
    // Extra wrap bit distinguishes full from empty when the index bits match.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop_vld) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module vector_wb_arbiter #(
    parameter int NUM_SRC      = 3,
    parameter int NUM_ELEMENTS = 32,
    parameter int ELEM_W       = 16,
    parameter int VREG_ADDR_W  = 5,
    parameter int DEPTH        = 2,
    localparam int SW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DW          = NUM_ELEMENTS * ELEM_W
) (
    input  logic                           CLK,
    input  logic                           nRST,
    input  logic [NUM_SRC-1:0]             src_valid,
    output logic [NUM_SRC-1:0]             src_ready,
    input  logic [NUM_SRC*VREG_ADDR_W-1:0] src_vd,
    input  logic [NUM_SRC*DW-1:0]          src_data,
    input  logic [NUM_SRC*NUM_ELEMENTS-1:0] src_mask,
    output logic                           wb_valid,
    input  logic                           wb_ready,
    output logic [VREG_ADDR_W-1:0]         wb_vd,
    output logic [DW-1:0]                  wb_data,
    output logic [NUM_ELEMENTS-1:0]        wb_mask,
    output logic [SW-1:0]                  wb_src,
    output logic                           busy
`ifdef VECTOR_WB_PERF_EN
    ,
    output logic [31:0]                    wb_stall_cnt,
    output logic [31:0]                    wb_done_cnt
`endif
);
    typedef struct packed {
        logic [VREG_ADDR_W-1:0]  vd;
        logic [DW-1:0]           data;
        logic [NUM_ELEMENTS-1:0] mask;
    } entry_t;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, state_nxt;
    entry_t             in_ent [NUM_SRC];
    entry_t             head   [NUM_SRC];
    logic [NUM_SRC-1:0] fifo_full, fifo_empty, pop_vec;
    logic [SW-1:0]      last_grant, grant, idx_s;
    logic               any_ne, load, found;
    int                 idx;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign in_ent[gi] = '{vd:   src_vd[gi*VREG_ADDR_W +: VREG_ADDR_W],
                              data: src_data[gi*DW +: DW],
                              mask: src_mask[gi*NUM_ELEMENTS +: NUM_ELEMENTS]};

        vector_wb_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
            .CLK      (CLK),
            .nRST     (nRST),
            .push_vld (src_valid[gi]),
            .push_dat (in_ent[gi]),
            .pop_vld  (pop_vec[gi]),
            .head_dat (head[gi]),
            .full     (fifo_full[gi]),
            .empty    (fifo_empty[gi])
        );
    end

    // Ready comes from registered occupancy only, so a full FIFO stays closed even while popping.
    assign src_ready = ~fifo_full;
    assign any_ne    = ~&fifo_empty;
    assign load      = ((state == IDLE) || wb_ready) && any_ne;
    assign pop_vec   = load ? (NUM_SRC'(1) << grant) : '0;
    assign wb_valid  = (state == HOLD);
    assign busy      = any_ne | wb_valid;

    // Round-robin: first non-empty source after the last one granted.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_s = '0;
        for (int off = 1; off <= NUM_SRC; off++) begin
            idx   = (int'(last_grant) + off) % NUM_SRC;
            idx_s = SW'(idx);
            if (!found && !fifo_empty[idx_s]) begin
                found = 1'b1;
                grant = idx_s;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (load)
            state_nxt = HOLD;
        else if ((state == HOLD) && wb_ready)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            last_grant <= SW'(NUM_SRC - 1);
            wb_vd      <= '0;
            wb_data    <= '0;
            wb_mask    <= '0;
            wb_src     <= '0;
        end else begin
            state <= state_nxt;
            if (load) begin
                last_grant <= grant;
                wb_vd      <= head[grant].vd;
                wb_data    <= head[grant].data;
                wb_mask    <= head[grant].mask;
                wb_src     <= grant;
            end
        end
    end

`ifdef VECTOR_WB_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wb_stall_cnt <= '0;
            wb_done_cnt  <= '0;
        end else begin
            if (wb_valid && !wb_ready && (wb_stall_cnt != '1))
                wb_stall_cnt <= wb_stall_cnt + 32'd1;
            if (wb_valid && wb_ready && (wb_done_cnt != '1))
                wb_done_cnt <= wb_done_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_vector_wb_arbiter.sv
// Directed bench for vector_wb_arbiter: reset, single push, round-robin, stall, masks, reset mid-flight, push+pop.
module tb_vector_wb_arbiter;
    localparam int NS = 3, NE = 32, EW = 16, VW = 5, DW = NE * EW;

    logic              CLK = 1'b0;
    logic              nRST;
    logic [NS-1:0]     src_valid, src_ready;
    logic [NS*VW-1:0]  src_vd;
    logic [NS*DW-1:0]  src_data;
    logic [NS*NE-1:0]  src_mask;
    logic              wb_valid, wb_ready, busy;
    logic [VW-1:0]     wb_vd;
    logic [DW-1:0]     wb_data;
    logic [NE-1:0]     wb_mask;
    logic [1:0]        wb_src;
`ifdef VECTOR_WB_PERF_EN
    logic [31:0]       wb_stall_cnt, wb_done_cnt;
`endif

    int total = 0;
    int bad   = 0;

    vector_wb_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .src_valid(src_valid), .src_ready(src_ready), .src_vd(src_vd),
        .src_data(src_data), .src_mask(src_mask),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_vd(wb_vd),
        .wb_data(wb_data), .wb_mask(wb_mask), .wb_src(wb_src), .busy(busy)
`ifdef VECTOR_WB_PERF_EN
        , .wb_stall_cnt(wb_stall_cnt), .wb_done_cnt(wb_done_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [DW-1:0] pat(input logic [15:0] s);
        logic [DW-1:0] r;
        for (int e = 0; e < NE; e++) r[e*EW +: EW] = s ^ 16'(e * 4099);
        return r;
    endfunction

    task automatic set_src(input int i, input logic [VW-1:0] vd, input logic [DW-1:0] d, input logic [NE-1:0] m);
        src_vd[i*VW +: VW]   = vd;
        src_data[i*DW +: DW] = d;
        src_mask[i*NE +: NE] = m;
    endtask

    task automatic apply_reset();
        src_valid = '0;
        wb_ready  = 1'b0;
        nRST      = 1'b0;
        tick();
        nRST      = 1'b1;
    endtask

    task automatic test_reset();
        src_valid = '0; wb_ready = 1'b0; src_vd = '0; src_data = '0; src_mask = '0;
        nRST = 1'b0;
        #2;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL rst_wb_valid got=%0h want=0", wb_valid); end
        total++; if (wb_vd !== 5'd0) begin bad++; $display("FAIL rst_wb_vd got=%0h want=0", wb_vd); end
        total++; if (wb_data !== '0) begin bad++; $display("FAIL rst_wb_data got=%0h want=0", wb_data); end
        total++; if (wb_mask !== 32'd0) begin bad++; $display("FAIL rst_wb_mask got=%0h want=0", wb_mask); end
        total++; if (wb_src !== 2'd0) begin bad++; $display("FAIL rst_wb_src got=%0h want=0", wb_src); end
        total++; if (src_ready !== 3'b111) begin bad++; $display("FAIL rst_src_ready got=%0b want=111", src_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
`ifdef VECTOR_WB_PERF_EN
        total++; if (wb_stall_cnt !== 32'd0 || wb_done_cnt !== 32'd0) begin bad++; $display("FAIL rst_perf got=%0h/%0h want=0/0", wb_stall_cnt, wb_done_cnt); end
`endif
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_single();
        logic [DW-1:0] d;
        apply_reset();
        for (int e = 0; e < NE; e++) d[e*EW +: EW] = 16'h3C00;
        wb_ready = 1'b1;
        set_src(1, 5'd7, d, 32'hFFFF_FFFF);
        src_valid = 3'b010;
        tick();
        src_valid = '0;
        total++; if (wb_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_k got=%0b%0b want=01", wb_valid, busy); end
        tick();
        total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", wb_valid); end
        total++; if (wb_vd !== 5'd7) begin bad++; $display("FAIL single_vd got=%0d want=7", wb_vd); end
        total++; if (wb_src !== 2'd1) begin bad++; $display("FAIL single_src got=%0d want=1", wb_src); end
        total++; if (wb_data !== d || wb_mask !== 32'hFFFF_FFFF) begin bad++; $display("FAIL single_payload got=%0h mask=%0h", wb_data, wb_mask); end
        tick();
        total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%0b%0b want=00", wb_valid, busy); end
    endtask

    task automatic test_round_robin();
        int seq [NS];
        int pseq [NS];
        int exp_rr = 0;
        int nloads = 0;
        logic [VW-1:0] ev;
        apply_reset();
        wb_ready = 1'b1;
        for (int i = 0; i < NS; i++) begin seq[i] = 0; pseq[i] = 0; end
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (wb_valid) begin
                ev = {2'(exp_rr), 3'(pseq[exp_rr])};
                total++; if (wb_src !== 2'(exp_rr)) begin bad++; $display("FAIL rr_src cyc=%0d got=%0d want=%0d", cyc, wb_src, exp_rr); end
                total++; if (wb_vd !== ev) begin bad++; $display("FAIL rr_vd cyc=%0d got=%0h want=%0h", cyc, wb_vd, ev); end
                pseq[exp_rr]++;
                exp_rr = (exp_rr + 1) % NS;
                nloads++;
            end
            for (int i = 0; i < NS; i++) set_src(i, {2'(i), 3'(seq[i])}, pat(16'(i * 16 + seq[i])), 32'hFFFF_FFFF);
            src_valid = 3'b111;
            for (int i = 0; i < NS; i++) if (src_ready[i]) seq[i]++;
            tick();
            if (cyc == 0) begin
                total++; if (src_ready !== 3'b111) begin bad++; $display("FAIL rr_ready1 got=%0b want=111", src_ready); end
            end
            if (cyc == 1) begin
                total++; if (src_ready !== 3'b001) begin bad++; $display("FAIL rr_ready2 got=%0b want=001", src_ready); end
            end
        end
        src_valid = '0;
        total++; if (nloads !== 8) begin bad++; $display("FAIL rr_loads got=%0d want=8", nloads); end
    endtask

    task automatic test_stall();
        apply_reset();
        wb_ready = 1'b0;
        src_valid = 3'b001;
        set_src(0, 5'd1, pat(16'd1), 32'hFFFF_FFFF);
        tick();
        set_src(0, 5'd2, pat(16'd2), 32'hFFFF_FFFF);
        tick();
        total++; if (wb_valid !== 1'b1 || wb_vd !== 5'd1) begin bad++; $display("FAIL stall_load got=%0b/%0d want=1/1", wb_valid, wb_vd); end
        set_src(0, 5'd3, pat(16'd3), 32'hFFFF_FFFF);
        tick();
        total++; if (src_ready[0] !== 1'b0) begin bad++; $display("FAIL stall_full got=%0b want=0", src_ready[0]); end
        set_src(0, 5'd4, pat(16'd4), 32'hFFFF_FFFF);
        for (int c = 0; c < 4; c++) begin
            tick();
            total++; if (wb_vd !== 5'd1 || wb_src !== 2'd0 || wb_data !== pat(16'd1) || wb_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold c=%0d got vd=%0d src=%0d v=%0b want vd=1 src=0 v=1", c, wb_vd, wb_src, wb_valid);
            end
        end
        total++; if (src_ready[0] !== 1'b0) begin bad++; $display("FAIL stall_still_full got=%0b want=0", src_ready[0]); end
`ifdef VECTOR_WB_PERF_EN
        total++; if (wb_stall_cnt !== 32'd5) begin bad++; $display("FAIL stall_cnt got=%0d want=5", wb_stall_cnt); end
`endif
        src_valid = '0;
        wb_ready = 1'b1;
        tick();
        total++; if (wb_vd !== 5'd2 || wb_valid !== 1'b1) begin bad++; $display("FAIL drain_b got=%0d want=2", wb_vd); end
        tick();
        total++; if (wb_vd !== 5'd3 || wb_valid !== 1'b1) begin bad++; $display("FAIL drain_c got=%0d want=3", wb_vd); end
        tick();
        total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL drain_idle got=%0b%0b want=00", wb_valid, busy); end
`ifdef VECTOR_WB_PERF_EN
        total++; if (wb_done_cnt !== 32'd3) begin bad++; $display("FAIL done_cnt got=%0d want=3", wb_done_cnt); end
`endif
    endtask

    task automatic test_mask();
        logic [DW-1:0] d;
        apply_reset();
        wb_ready = 1'b1;
        for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
        set_src(2, 5'd9, d, 32'h0000_0001);
        src_valid = 3'b100;
        tick();
        set_src(2, 5'd10, ~d, 32'h0000_0000);
        tick();
        src_valid = '0;
        total++; if (wb_src !== 2'd2 || wb_vd !== 5'd9) begin bad++; $display("FAIL mask_hdr got=%0d/%0d want=2/9", wb_src, wb_vd); end
        total++; if (wb_mask !== 32'h0000_0001) begin bad++; $display("FAIL mask_one got=%0h want=1", wb_mask); end
        total++; if (wb_data !== d) begin bad++; $display("FAIL mask_data got=%0h want=%0h", wb_data, d); end
        tick();
        total++; if (wb_valid !== 1'b1 || wb_mask !== 32'h0 || wb_vd !== 5'd10 || wb_data !== ~d) begin
            bad++; $display("FAIL mask_zero got v=%0b mask=%0h vd=%0d want v=1 mask=0 vd=10", wb_valid, wb_mask, wb_vd);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        wb_ready = 1'b0;
        for (int i = 0; i < NS; i++) set_src(i, 5'(i + 20), pat(16'(i + 40)), 32'hFFFF_FFFF);
        src_valid = 3'b111;
        repeat (3) tick();
        total++; if (src_ready !== 3'b000 || wb_valid !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0b/%0b want=000/1", src_ready, wb_valid); end
        src_valid = '0;
        #2;
        nRST = 1'b0;
        #1;
        total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_valid_busy got=%0b%0b want=00", wb_valid, busy); end
        total++; if (src_ready !== 3'b111) begin bad++; $display("FAIL mid_ready got=%0b want=111", src_ready); end
        total++; if (wb_vd !== 5'd0 || wb_src !== 2'd0 || wb_data !== '0) begin bad++; $display("FAIL mid_payload got vd=%0d src=%0d want 0/0", wb_vd, wb_src); end
        tick();
        nRST = 1'b1;
        wb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_stale c=%0d got=%0b%0b want=00", c, wb_valid, busy); end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        wb_ready = 1'b1;
        src_valid = 3'b001;
        set_src(0, 5'd1, pat(16'd11), '1);
        tick();
        for (int k = 2; k <= 4; k++) begin
            set_src(0, 5'(k), pat(16'(10 + k)), '1);
            tick();
            total++; if (wb_vd !== 5'(k - 1) || wb_valid !== 1'b1) begin bad++; $display("FAIL b2b_vd k=%0d got=%0d want=%0d", k, wb_vd, k - 1); end
            total++; if (src_ready[0] !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL b2b_count k=%0d ready=%0b busy=%0b want=1/1", k, src_ready[0], busy); end
        end
        src_valid = '0;
        tick();
        total++; if (wb_vd !== 5'd4 || wb_data !== pat(16'd14)) begin bad++; $display("FAIL b2b_last got=%0d want=4", wb_vd); end
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b want=0", wb_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_mask();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
